// File: rtl/edge_mark.sv
// Single-pass edge marker: streams the 1-bit foreground mask in raster order.
// Writes 3'b011 for foreground pixels that touch background (4-neighbourhood), 3'b000 elsewhere.
module edge_mark #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        mask_read,
    output logic [18:0] mask_addr,
    output logic        edge_we,
    output logic [18:0] edge_addr_write,
    output logic [2:0]  bram_write,
    output logic        busy,
    output logic        done,
    output logic [18:0] num_edge
);
    localparam logic [18:0] NPIX   = 19'(WIDTH * HEIGHT);
    localparam logic [18:0] LAST_N = 19'(WIDTH * HEIGHT + WIDTH - 1);
    localparam logic [18:0] W19    = 19'(WIDTH);
    localparam logic [18:0] XMAX   = 19'(WIDTH - 1);
    localparam logic [18:0] YMAX   = 19'(HEIGHT - 1);
    localparam int          DLY    = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic             w_launch;
    logic [18:0]      r_n;
    logic             r_v1;
    logic             r_v2;
    logic [18:0]      r_n1;
    logic [18:0]      r_n2;
    logic [DLY-1:0]   r_dly;
    logic [18:0]      r_kx;
    logic [18:0]      r_ky;
    logic [18:0]      r_k;
    logic             r_edge_we;
    logic [18:0]      r_edge_addr;
    logic [2:0]       r_bram_write;
    logic [18:0]      r_num_edge;
    logic             w_sample;
    logic             w_interior;
    logic             w_edge;

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = RUN;
            RUN:     if (r_n == LAST_N) w_next = DRAIN;
            DRAIN:   if (r_edge_we && (r_edge_addr == NPIX - 19'd1)) w_next = DONE;
            DONE:    if (start) w_next = RUN;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        busy     = (r_state == RUN) || (r_state == DRAIN);
        done     = (r_state == DONE);
        w_launch = ((r_state == IDLE) || (r_state == DONE)) && start;
    end

    // Reads past the last pixel only flush the delay line; their data is forced to 0.
    assign mask_addr = (r_n >= NPIX) ? (NPIX - 19'd1) : r_n;
    assign w_sample  = (r_n2 >= NPIX) ? 1'b0 : mask_read;

    // Taps relative to incoming sample n: r_dly[j] holds sample n-1-j.
    assign w_interior = (r_kx != 19'd0) && (r_kx != XMAX) && (r_ky != 19'd0) && (r_ky != YMAX);
    assign w_edge     = w_interior && r_dly[WIDTH-1]
                      && !(w_sample && r_dly[WIDTH-2] && r_dly[WIDTH] && r_dly[DLY-1]);

    always_ff @(posedge clk) begin
        if (reset || w_launch) begin
            r_n          <= '0;
            r_v1         <= 1'b0;
            r_v2         <= 1'b0;
            r_n1         <= '0;
            r_n2         <= '0;
            r_dly        <= '0;
            r_kx         <= '0;
            r_ky         <= '0;
            r_k          <= '0;
            r_edge_we    <= 1'b0;
            r_edge_addr  <= '0;
            r_bram_write <= '0;
            r_num_edge   <= '0;
        end else begin
            if ((r_state == RUN) && (r_n != LAST_N)) r_n <= r_n + 19'd1;
            // Two-stage tag pipeline matching the fixed BRAM read latency.
            r_v1      <= (r_state == RUN);
            r_n1      <= r_n;
            r_v2      <= r_v1;
            r_n2      <= r_n1;
            r_edge_we <= 1'b0;
            if (r_v2) begin
                r_dly <= {r_dly[DLY-2:0], w_sample};
                if (r_n2 >= W19) begin
                    r_edge_we    <= 1'b1;
                    r_edge_addr  <= r_k;
                    r_bram_write <= w_edge ? 3'b011 : 3'b000;
                    if (w_edge) r_num_edge <= r_num_edge + 19'd1;
                    r_k <= r_k + 19'd1;
                    if (r_kx == XMAX) begin
                        r_kx <= '0;
                        r_ky <= r_ky + 19'd1;
                    end else begin
                        r_kx <= r_kx + 19'd1;
                    end
                end
            end
        end
    end

    assign edge_we         = r_edge_we;
    assign edge_addr_write = r_edge_addr;
    assign bram_write      = r_bram_write;
    assign num_edge        = r_num_edge;
endmodule

// File: tb/tb_edge_mark.sv
// Bench for edge_mark on an 8x6 frame: mask BRAM model with 2-cycle latency,
// golden edge map queued per pass and compared against every edge BRAM write.
module tb_edge_mark;
    localparam int W = 8;
    localparam int H = 6;

    logic        clk;
    logic        reset;
    logic        start;
    logic        mask_read;
    logic [18:0] mask_addr;
    logic        edge_we;
    logic [18:0] edge_addr_write;
    logic [2:0]  bram_write;
    logic        busy;
    logic        done;
    logic [18:0] num_edge;

    logic        mask_mem [0:W*H-1];
    logic        p1;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [2:0]  exp_q[$];
    logic [18:0] exp_addr_q[$];

    edge_mark #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk(clk), .reset(reset), .start(start), .mask_read(mask_read),
        .mask_addr(mask_addr), .edge_we(edge_we), .edge_addr_write(edge_addr_write),
        .bram_write(bram_write), .busy(busy), .done(done), .num_edge(num_edge)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Mask BRAM: data for the address seen at cycle t is valid during t+2.
    always @(posedge clk) begin
        p1        <= mask_mem[int'(mask_addr)];
        mask_read <= p1;
    end

    task automatic build_expected(output int cnt);
        int  x;
        int  y;
        logic e;
        exp_q.delete();
        exp_addr_q.delete();
        cnt = 0;
        for (int k = 0; k < W*H; k++) begin
            x = k % W;
            y = k / W;
            e = 1'b0;
            if (x > 0 && x < W-1 && y > 0 && y < H-1)
                e = mask_mem[k] && !(mask_mem[k-1] && mask_mem[k+1] && mask_mem[k-W] && mask_mem[k+W]);
            exp_q.push_back(e ? 3'b011 : 3'b000);
            exp_addr_q.push_back(19'(k));
            if (e) cnt++;
        end
    endtask

    task automatic clear_mask();
        for (int i = 0; i < W*H; i++) mask_mem[i] = 1'b0;
    endtask

    // exp_num < 0 takes the model count; abort_at >= 0 resets the DUT at s+abort_at.
    task automatic run_pass(input string name, input int repulse_at, input int abort_at, input int exp_num);
        int   s;
        int   model_cnt;
        int   want_num;
        int   first_cyc;
        bit   fin;
        logic [2:0]  ed;
        logic [18:0] ea;
        build_expected(model_cnt);
        want_num  = (exp_num >= 0) ? exp_num : model_cnt;
        first_cyc = -1;
        fin       = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        s = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b1 || mask_addr !== 19'd0) begin
            n_fail++;
            $display("FAIL %s launch: done=%b busy=%b mask_addr=%0d, expected 0 1 0", name, done, busy, mask_addr);
        end
        while (!fin && cyc < s + W*H + W + 40) begin
            if (edge_we) begin
                if (first_cyc < 0) begin
                    first_cyc = cyc;
                    n_checks++;
                    if (first_cyc != s + W + 4) begin
                        n_fail++;
                        $display("FAIL %s first write: cycle s+%0d, expected s+%0d", name, first_cyc - s, W + 4);
                    end
                end
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL %s extra write: addr %0d data %b, expected none", name, edge_addr_write, bram_write);
                end else begin
                    ed = exp_q.pop_front();
                    ea = exp_addr_q.pop_front();
                    if (edge_addr_write !== ea || bram_write !== ed) begin
                        n_fail++;
                        $display("FAIL %s write: addr %0d data %b, expected addr %0d data %b",
                                 name, edge_addr_write, bram_write, ea, ed);
                    end
                end
            end
            if (done === 1'b1) begin
                fin = 1'b1;
                n_checks++;
                if (cyc != s + W*H + W + 4) begin
                    n_fail++;
                    $display("FAIL %s done time: s+%0d, expected s+%0d", name, cyc - s, W*H + W + 4);
                end
                n_checks++;
                if (num_edge !== 19'(want_num) || busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s num_edge: %0d busy=%b, expected %0d busy=0", name, num_edge, busy, want_num);
                end
                n_checks++;
                if (exp_q.size() != 0) begin
                    n_fail++;
                    $display("FAIL %s missing writes: %0d left, expected 0", name, exp_q.size());
                end
            end else if (abort_at >= 0 && cyc - s == abort_at) begin
                reset = 1'b1;
                @(posedge clk); #1;
                reset = 1'b0;
                n_checks++;
                if (edge_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || num_edge !== 19'd0 ||
                    edge_addr_write !== 19'd0 || bram_write !== 3'd0 || mask_addr !== 19'd0) begin
                    n_fail++;
                    $display("FAIL %s after reset: we=%b busy=%b done=%b num=%0d addr=%0d data=%b maddr=%0d, expected all 0",
                             name, edge_we, busy, done, num_edge, edge_addr_write, bram_write, mask_addr);
                end
                for (int i = 0; i < 5; i++) begin
                    @(posedge clk); #1;
                    n_checks++;
                    if (edge_we !== 1'b0 || busy !== 1'b0) begin
                        n_fail++;
                        $display("FAIL %s idle after reset: we=%b busy=%b, expected 0 0", name, edge_we, busy);
                    end
                end
                exp_q.delete();
                exp_addr_q.delete();
                return;
            end else begin
                start = (cyc - s == repulse_at);
                @(posedge clk); #1;
            end
        end
        start = 1'b0;
        if (!fin) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s timeout: done never rose, expected at s+%0d", name, W*H + W + 4);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        clear_mask();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        n_checks++;
        if (edge_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || num_edge !== 19'd0 ||
            edge_addr_write !== 19'd0 || bram_write !== 3'd0 || mask_addr !== 19'd0) begin
            n_fail++;
            $display("FAIL reset state: we=%b busy=%b done=%b num=%0d addr=%0d data=%b maddr=%0d, expected all 0",
                     edge_we, busy, done, num_edge, edge_addr_write, bram_write, mask_addr);
        end
    endtask

    task automatic test_zero_mask();
        clear_mask();
        run_pass("zero_mask", -1, -1, 0);
    endtask

    task automatic test_block();
        clear_mask();
        for (int y = 2; y <= 4; y++)
            for (int x = 2; x <= 4; x++)
                mask_mem[y*W + x] = 1'b1;
        run_pass("block3x3", -1, -1, 8);
    endtask

    task automatic test_all_ones();
        for (int i = 0; i < W*H; i++) mask_mem[i] = 1'b1;
        run_pass("all_ones", -1, -1, 0);
    endtask

    task automatic test_single_pixel();
        clear_mask();
        mask_mem[1*W + 1] = 1'b1;
        run_pass("pixel_1_1", -1, -1, 1);
        clear_mask();
        mask_mem[1*W + 7] = 1'b1;
        run_pass("pixel_7_1", -1, -1, 0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < W*H; i++) mask_mem[i] = ($urandom_range(0, 3) != 0);
            run_pass("random", -1, -1, -1);
        end
    endtask

    task automatic test_reset_mid_pass();
        for (int i = 0; i < W*H; i++) mask_mem[i] = ($urandom_range(0, 2) != 0);
        run_pass("reset_mid", -1, 30, -1);
        run_pass("after_reset", -1, -1, -1);
    endtask

    task automatic test_back_to_back();
        clear_mask();
        for (int y = 1; y <= 4; y++)
            for (int x = 1; x <= 5; x++)
                mask_mem[y*W + x] = 1'b1;
        run_pass("repulse_run", 5, -1, -1);
        run_pass("restart_done", -1, -1, -1);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        test_reset();
        test_zero_mask();
        test_block();
        test_all_ones();
        test_single_pixel();
        test_random();
        test_reset_mid_pass();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
